// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the Pong datapath.
package pong_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, LAUNCH, PLAY} serve_state_t;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/ball_serve.sv
// ball_serve: holds the ball at centre for a frame delay, then launches it with random vertical motion.
module ball_serve
    import pong_pkg::*;
#(
    parameter int RND_W        = 3,
    parameter int DELAY_FRAMES = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             start_btn,
    input  logic             goal_left,
    input  logic             goal_right,
    input  logic [RND_W-1:0] rnd,
    output logic             vx_dir,
    output logic             vy_dir,
    output logic [1:0]       vy_speed,
    output logic             serve_valid,
    output logic             ball_enable,
    output logic             ball_reset
);
    localparam int CW = DELAY_FRAMES > 0 ? $clog2(DELAY_FRAMES + 1) : 1;
    localparam logic [CW-1:0] DLY = CW'(DELAY_FRAMES);

    serve_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic pend, pend_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pend     <= DIR_RIGHT;
            vx_dir   <= DIR_RIGHT;
            vy_dir   <= 1'b0;
            vy_speed <= 2'd1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
            if (state == LAUNCH) begin
                vx_dir   <= pend;
                vy_dir   <= rnd[0];
                vy_speed <= rnd[2:1] == 2'd0 ? 2'd1 : rnd[2:1];
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend;
        case (state)
            IDLE: begin
                pend_n = DIR_RIGHT;
                if (start_btn) begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end
            end
            WAIT: begin
                if (DELAY_FRAMES == 0) state_n = LAUNCH;
                else if (frame_tick && cnt != DLY) begin
                    cnt_n = cnt + 1'b1;
                    if (cnt + 1'b1 == DLY) state_n = LAUNCH;
                end
            end
            LAUNCH: state_n = PLAY;
            PLAY: begin
                // goal_left has priority when both goals land together
                if (goal_left || goal_right) begin
                    pend_n  = goal_left ? DIR_LEFT : DIR_RIGHT;
                    state_n = WAIT;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign serve_valid = state == LAUNCH;
    assign ball_enable = state == PLAY;
    assign ball_reset  = state == IDLE || state == WAIT;
endmodule

// File: tb/tb_ball_serve.sv
// tb_ball_serve: random and directed stimulus on two delay settings against a behavioural serve model.
module tb_ball_serve;
    logic clk = 1'b0;
    logic rst = 1'b1, frame_tick = 1'b0, start_btn = 1'b0, goal_left = 1'b0, goal_right = 1'b0;
    logic [2:0] rnd = 3'b101;
    logic [1:0] vx, vy, sv, be, br;
    logic [1:0] spd [2];
    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ball_serve #(.RND_W(3), .DELAY_FRAMES(3)) dut3 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
        .goal_left(goal_left), .goal_right(goal_right), .rnd(rnd),
        .vx_dir(vx[0]), .vy_dir(vy[0]), .vy_speed(spd[0]),
        .serve_valid(sv[0]), .ball_enable(be[0]), .ball_reset(br[0]));

    ball_serve #(.RND_W(3), .DELAY_FRAMES(0)) dut0 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
        .goal_left(goal_left), .goal_right(goal_right), .rnd(rnd),
        .vx_dir(vx[1]), .vy_dir(vy[1]), .vy_speed(spd[1]),
        .serve_valid(sv[1]), .ball_enable(be[1]), .ball_reset(br[1]));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: a serve is a phase (idle, holding for ticks, launching, in play) plus the launch registers.
    int  delay [2] = '{3, 0};
    bit  idle [2] = '{1, 1}, holding [2] = '{0, 0}, launching [2] = '{0, 0}, playing [2] = '{0, 0};
    int  ticks_seen [2] = '{0, 0};
    bit  toward [2] = '{1, 1}, m_vx [2] = '{1, 1}, m_vy [2] = '{0, 0};
    int  m_spd [2] = '{1, 1};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                {idle[k], holding[k], launching[k], playing[k]} = 4'b1000;
                ticks_seen[k] = 0; toward[k] = 1; m_vx[k] = 1; m_vy[k] = 0; m_spd[k] = 1;
            end else if (idle[k]) begin
                toward[k] = 1;
                if (start_btn) begin idle[k] = 0; holding[k] = 1; ticks_seen[k] = 0; end
            end else if (holding[k]) begin
                if (delay[k] == 0) begin holding[k] = 0; launching[k] = 1; end
                else if (frame_tick) begin
                    ticks_seen[k] = ticks_seen[k] + 1;
                    if (ticks_seen[k] >= delay[k]) begin holding[k] = 0; launching[k] = 1; end
                end
            end else if (launching[k]) begin
                m_vx[k] = toward[k];
                m_vy[k] = rnd[0];
                m_spd[k] = (rnd >> 1) == 0 ? 1 : int'(rnd >> 1);
                launching[k] = 0; playing[k] = 1;
            end else if (goal_left || goal_right) begin
                toward[k] = goal_left ? 1'b0 : 1'b1;
                playing[k] = 0; holding[k] = 1; ticks_seen[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("vx_dir[%0d]", k), int'(vx[k]), int'(m_vx[k]));
                check($sformatf("vy_dir[%0d]", k), int'(vy[k]), int'(m_vy[k]));
                check($sformatf("vy_speed[%0d]", k), int'(spd[k]), m_spd[k]);
                check($sformatf("serve_valid[%0d]", k), int'(sv[k]), int'(launching[k]));
                check($sformatf("ball_enable[%0d]", k), int'(be[k]), int'(playing[k]));
                check($sformatf("ball_reset[%0d]", k), int'(br[k]), int'(idle[k] | holding[k]));
            end
        end
    end

    task automatic tick_after_gap();
        repeat (9) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset vx_dir", int'(vx[0]), 1);
        check("reset vy_speed", int'(spd[0]), 1);
        check("reset ball_reset", int'(br[0]), 1);
        rst = 1'b0; start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        repeat (3) tick_after_gap();
        check("launch after 3rd tick", int'(sv[0]), 1);
        @(negedge clk);
        check("play enable", int'(be[0]), 1);
        check("first vx", int'(vx[0]), 1);
        check("first vy", int'(vy[0]), 1);
        check("first speed", int'(spd[0]), 2);
        rnd = 3'b000;
        goal_left = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        goal_left = 1'b0; frame_tick = 1'b0;
        check("goal enable off", int'(be[0]), 0);
        check("goal ball_reset", int'(br[0]), 1);
        goal_right = 1'b1;
        repeat (3) tick_after_gap();
        goal_right = 1'b0;
        check("stray goal launch", int'(sv[0]), 1);
        @(negedge clk);
        check("left serve vx", int'(vx[0]), 0);
        check("zero speed map", int'(spd[0]), 1);
        check("zero speed vy", int'(vy[0]), 0);
        goal_left = 1'b1; goal_right = 1'b1;
        @(negedge clk);
        goal_left = 1'b0; goal_right = 1'b0;
        repeat (3) tick_after_gap();
        @(negedge clk);
        check("both goals vx", int'(vx[0]), 0);
        goal_right = 1'b1;
        @(negedge clk);
        goal_right = 1'b0;
        repeat (3) tick_after_gap();
        @(negedge clk);
        check("right serve vx", int'(vx[0]), 1);
        goal_left = 1'b1;
        @(negedge clk);
        goal_left = 1'b0;
        repeat (2) tick_after_gap();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-wait reset ball_reset", int'(br[0]), 1);
        check("mid-wait reset vx", int'(vx[0]), 1);
        repeat (4) tick_after_gap();
        check("no serve without start", int'(sv[0]), 0);
        check("still idle", int'(br[0]), 1);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            rst        = $urandom_range(299) == 0;
            start_btn  = $urandom_range(15) == 0;
            frame_tick = $urandom_range(2) == 0;
            goal_left  = $urandom_range(19) == 0;
            goal_right = $urandom_range(19) == 0;
            rnd        = 3'($urandom);
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ball_serve.md
# ball_serve

Serve controller for the Pong datapath. It sits directly downstream of the LFSR random generator and directly upstream of the ball motion block. It waits for a start command or a goal, holds the ball at centre for a fixed number of frames, then samples the random bits once to pick the launch direction and vertical speed. It then enables ball motion until the next goal.

## Interface
- `RND_W`, default 3: width of random input; must be ≥3.
- `DELAY_FRAMES`, default 60: frame ticks spent in WAIT before launch; range 0..1023.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse per video frame.
- `start_btn`, in, 1: level; starts the first serve from IDLE.
- `goal_left`, in, 1: one-cycle pulse, ball passed the left paddle.
- `goal_right`, in, 1: one-cycle pulse, ball passed the right paddle.
- `rnd`, in, RND_W: free-running LFSR output, sampled only in LAUNCH.
- `vx_dir`, out, 1: horizontal direction; 1 = right, 0 = left.
- `vy_dir`, out, 1: vertical direction; 1 = down, 0 = up.
- `vy_speed`, out, 2: vertical speed in pixels/frame, 1..3, never 0.
- `serve_valid`, out, 1: one-cycle pulse; new launch parameters are valid.
- `ball_enable`, out, 1: ball motion block may move the ball.
- `ball_reset`, out, 1: ball motion block holds the ball at screen centre.

## Operation
- FSM states in `serve_state_t`: IDLE, WAIT, LAUNCH, PLAY.
- **IDLE**
  - Transitions to WAIT when `start_btn` = 1.
  - Pending direction is set to right (1).
- **WAIT**
  - Delay counter is cleared on entry.
  - Each `frame_tick` increments the counter.
  - On the tick that makes the count equal DELAY_FRAMES, the FSM moves to LAUNCH on the next cycle.
  - With DELAY_FRAMES = 0, WAIT lasts exactly one cycle and ticks are ignored.
- **LAUNCH** (exactly one cycle)
  - `vx_dir` <= pending direction.
  - `vy_dir` <= `rnd[0]`.
  - `vy_speed` <= `rnd[2:1]`, except that 2'b00 maps to 2'b01.
  - `serve_valid` = 1.
  - Next state: PLAY.
- **PLAY**
  - `goal_left` → pending direction = left (serve toward the player who conceded); next state WAIT.
  - `goal_right` → pending direction = right; next state WAIT.
  - If both goal pulses arrive in the same cycle, `goal_left` wins.
- Goal pulses outside PLAY are ignored.
- `start_btn` outside IDLE is ignored.
- Output decode:
  - `ball_enable` = 1 only in PLAY.
  - `ball_reset` = 1 in IDLE and WAIT.
  - Both are 0 in LAUNCH.
- `vx_dir`, `vy_dir` and `vy_speed` are registered and hold their value until the next LAUNCH.
- The block keeps no score. Scoring is the downstream score block's job.

## Timing
- Reset values:
  - state IDLE, counter 0, pending direction 1.
  - `vx_dir` = 1, `vy_dir` = 0, `vy_speed` = 1.
  - `serve_valid` = 0, `ball_enable` = 0, `ball_reset` = 1.
- `rst` mid-operation returns the FSM to IDLE on the next edge. All outputs take their reset values, and any pending launch is dropped.
- A goal in PLAY at cycle t puts the FSM in WAIT at t+1, with `ball_enable` = 0 and `ball_reset` = 1.
- A `frame_tick` in the same cycle as the goal does not count toward the delay.
- The serve_valid edge follows the DELAY_FRAMES-th tick by 1 cycle. `ball_enable` rises 1 cycle after `serve_valid`.
- `rnd` is sampled at the clock edge that ends LAUNCH. Launch outputs change on that same edge, i.e. they are visible in the first PLAY cycle alongside `ball_enable`.
- The counter must not wrap. It saturates at DELAY_FRAMES, and its width is $clog2(DELAY_FRAMES+1), with a minimum of 1.

## Structure
- Shared package `pong_pkg` holds:
  - `typedef enum logic [1:0] serve_state_t`.
  - Constants `DIR_LEFT` = 1'b0 and `DIR_RIGHT` = 1'b1.
- No sub-module. The frame-delay counter and FSM are inline.
- The LFSR is instantiated by the parent and wired to `rnd`.

## Test plan
- **Reset then start:** reset, `start_btn` = 1 one cycle, DELAY_FRAMES = 3, ticks every 10 cycles, `rnd` = 3'b101.
  - `serve_valid` 1 cycle after the 3rd tick.
  - `vx_dir` = 1, `vy_dir` = 1, `vy_speed` = 2.
  - `ball_enable` high the next cycle.
- **Zero-speed mapping:** `rnd` = 3'b000 at LAUNCH → `vy_speed` = 1, `vy_dir` = 0.
- **Goal direction:** `goal_left` in PLAY → WAIT next cycle, `ball_enable` = 0, next launch `vx_dir` = 0. Then `goal_right` → next launch `vx_dir` = 1.
- **Simultaneous and stray events:**
  - `goal_left` and `goal_right` in the same cycle → `vx_dir` = 0 at next launch.
  - Goal pulses during WAIT → no state change, delay unaffected.
- **Reset mid-WAIT:** `rst` after 2 of 3 ticks → IDLE, `ball_reset` = 1, no `serve_valid` until a new `start_btn`.
- **DELAY_FRAMES = 0:** `start_btn` → WAIT 1 cycle, LAUNCH the next cycle, no `frame_tick` needed.
